// File: rtl/rmt_pkg.sv
// Shared types and constants for the match router: key layout, FSM states, offset defaults.
// No logic; consumed by rmt_match_table and rmt_match_router.
// Backpressure: not applicable.
package rmt_pkg;

    localparam int KEY_WIDTH   = 48;
    localparam int FIELD_WIDTH = 16;

    localparam int DEF_ETYPE_OFFSET = 12;
    localparam int DEF_DELIM_OFFSET = 42;
    localparam int DEF_FUNC_OFFSET  = 44;

    // Packet handling state: waiting for beat 0, passing a frame, or swallowing one
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Lookup key as it sits in the table: {etype, delim, func}, each in network byte order
    typedef struct packed {
        logic [FIELD_WIDTH-1:0] etype;
        logic [FIELD_WIDTH-1:0] delim;
        logic [FIELD_WIDTH-1:0] func;
    } key_t;

    // Largest of the three field offsets; the runt check needs the byte after it
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rmt_match_table.sv
// Masked match table with a single config write port and a combinational priority lookup.
// Latency: lookup is combinational; a write takes effect after the clock edge it is sampled on.
// Backpressure: none; the lookup result is only consumed by the caller on its own handshake.
module rmt_match_table
    import rmt_pkg::*;
#(
    parameter int RULE_COUNT = 8,
    parameter int DEST_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    input  logic [KEY_WIDTH-1:0]  cfg_key,
    input  logic [KEY_WIDTH-1:0]  cfg_mask,
    input  logic                  cfg_drop,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  key_t                  lookup_key,
    output logic                  hit,
    output logic                  hit_drop,
    output logic [DEST_WIDTH-1:0] hit_dest
);

    logic [RULE_COUNT-1:0] rule_valid;
    logic [RULE_COUNT-1:0] rule_drop;
    logic [KEY_WIDTH-1:0]  rule_key  [RULE_COUNT];
    logic [KEY_WIDTH-1:0]  rule_mask [RULE_COUNT];
    logic [DEST_WIDTH-1:0] rule_dest [RULE_COUNT];

    // Rule storage: reset invalidates everything, a write pulse replaces one whole entry
    always_ff @(posedge clk) begin
        if (rst) begin
            rule_valid <= '0;
            rule_drop  <= '0;
            for (int i = 0; i < RULE_COUNT; i++) begin
                rule_key[i]  <= '0;
                rule_mask[i] <= '0;
                rule_dest[i] <= '0;
            end
        end else if (cfg_wr_en && (32'(cfg_addr) < RULE_COUNT)) begin
            rule_valid[cfg_addr] <= cfg_valid;
            rule_drop[cfg_addr]  <= cfg_drop;
            rule_key[cfg_addr]   <= cfg_key;
            rule_mask[cfg_addr]  <= cfg_mask;
            rule_dest[cfg_addr]  <= cfg_dest;
        end
    end

    // Priority lookup: scan high to low so the lowest matching index is the one left standing
    always_comb begin
        hit      = 1'b0;
        hit_drop = 1'b0;
        hit_dest = '0;
        for (int i = RULE_COUNT - 1; i >= 0; i--) begin
            if (rule_valid[i] && (((lookup_key ^ rule_key[i]) & rule_mask[i]) == '0)) begin
                hit      = 1'b1;
                hit_drop = rule_drop[i];
                hit_dest = rule_dest[i];
            end
        end
    end

endmodule

// File: rtl/rmt_match_router.sv
// AXI-Stream classifier: looks up beat-0 header fields, then forwards the frame with a tdest or drops it.
// Latency: one cycle through a registered output slice; full throughput with no bubbles.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready, forced high while dropping.
module rmt_match_router
    import rmt_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 8,
    parameter int DEST_WIDTH   = 4,
    parameter int RULE_COUNT   = 8,
    parameter int ETYPE_OFFSET = DEF_ETYPE_OFFSET,
    parameter int DELIM_OFFSET = DEF_DELIM_OFFSET,
    parameter int FUNC_OFFSET  = DEF_FUNC_OFFSET,
    parameter bit DEFAULT_DROP = 1'b1,
    parameter int DEFAULT_DEST = 0,
    parameter int CNT_WIDTH    = 32,
    localparam int ADDR_WIDTH  = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    input  logic [KEY_WIDTH-1:0]  cfg_key,
    input  logic [KEY_WIDTH-1:0]  cfg_mask,
    input  logic                  cfg_drop,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    output logic [CNT_WIDTH-1:0]  stat_fwd_pkts,
    output logic [CNT_WIDTH-1:0]  stat_drop_pkts
);

    // Beat 0 must carry the last header byte, otherwise the key is incomplete and treated as a miss
    localparam int MAX_OFFSET = max3(ETYPE_OFFSET, DELIM_OFFSET, FUNC_OFFSET);

    state_t                state_q, state_d;
    key_t                  in_key;
    logic                  in_hs;
    logic                  runt;
    logic                  tbl_hit, tbl_drop;
    logic [DEST_WIDTH-1:0] tbl_dest;
    logic                  dec_drop;
    logic [DEST_WIDTH-1:0] dec_dest;
    logic [DEST_WIDTH-1:0] cur_dest;
    logic                  emit, decide;

    // Header extraction in network byte order: first byte on the wire is the field MSB
    always_comb begin
        in_key.etype = {s_axis_tdata[8*ETYPE_OFFSET +: 8], s_axis_tdata[8*(ETYPE_OFFSET+1) +: 8]};
        in_key.delim = {s_axis_tdata[8*DELIM_OFFSET +: 8], s_axis_tdata[8*(DELIM_OFFSET+1) +: 8]};
        in_key.func  = {s_axis_tdata[8*FUNC_OFFSET +: 8],  s_axis_tdata[8*(FUNC_OFFSET+1) +: 8]};
    end

    rmt_match_table #(
        .RULE_COUNT (RULE_COUNT),
        .DEST_WIDTH (DEST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .cfg_key    (cfg_key),
        .cfg_mask   (cfg_mask),
        .cfg_drop   (cfg_drop),
        .cfg_dest   (cfg_dest),
        .lookup_key (in_key),
        .hit        (tbl_hit),
        .hit_drop   (tbl_drop),
        .hit_dest   (tbl_dest)
    );

    assign runt          = !s_axis_tkeep[MAX_OFFSET + 1];
    assign dec_drop      = (tbl_hit && !runt) ? tbl_drop : DEFAULT_DROP;
    assign dec_dest      = (tbl_hit && !runt) ? tbl_dest : DEST_WIDTH'(DEFAULT_DEST);
    assign s_axis_tready = !rst && ((state_q == ST_DROP) || !m_axis_tvalid || m_axis_tready);
    assign in_hs         = s_axis_tvalid && s_axis_tready;

    // Next-state and per-beat actions; the classification happens only on the beat-0 handshake
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        decide  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    decide = 1'b1;
                    emit   = !dec_drop;
                    if (!s_axis_tlast) begin
                        state_d = dec_drop ? ST_DROP : ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (in_hs) begin
                    emit = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (in_hs && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-packet destination latched at the decision so mid-packet rule writes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_dest <= '0;
        end else if (decide) begin
            cur_dest <= dec_dest;
        end
    end

    // Output slice: load on an emitted beat, clear valid once drained, otherwise hold steady
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tdest  <= '0;
        end else if (emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tdest  <= (state_q == ST_IDLE) ? dec_dest : cur_dest;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Packet counters, one bump per decision, pinned at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fwd_pkts  <= '0;
            stat_drop_pkts <= '0;
        end else if (decide) begin
            if (dec_drop) begin
                if (stat_drop_pkts != '1) stat_drop_pkts <= stat_drop_pkts + 1'b1;
            end else begin
                if (stat_fwd_pkts != '1) stat_fwd_pkts <= stat_fwd_pkts + 1'b1;
            end
        end
    end

endmodule
